// File: rtl/stopwatch_pkg.sv
// Shared types and digit helpers for the stopwatch time-keeping core.
// Digits are carried as 5-bit values to match the display driver interface.
package stopwatch_pkg;

  typedef enum logic {
    PAUSED = 1'b0,
    RUN    = 1'b1
  } state_t;

  typedef logic [4:0] digit_t;

  localparam digit_t DIGIT_MAX    = 5'd9;
  localparam digit_t SEC_TENS_MAX = 5'd5;

  // Comparisons use >= so an out-of-range digit is pulled back to 0 instead of running away.
  function automatic logic digit_wraps(input digit_t d, input digit_t max);
    return d >= max;
  endfunction

  function automatic digit_t digit_inc(input digit_t d, input digit_t max);
    return (d >= max) ? 5'd0 : d + 5'd1;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running prescaler: counts 0..DIV-1 while enabled and pulses tick in the last cycle.
// clr beats en; with en low the count simply holds, which lets a paused stopwatch keep its fraction.
module tick_divider #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int           W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      if (count == LAST) begin
        count <= '0;
      end else begin
        count <= count + W'(1);
      end
    end
  end

  assign tick = en && !clr && (count == LAST);

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch core: run/adjust prescalers, pause/run FSM and the BCD carry chain.
// Adjust mode freezes normal counting and steps the selected field at the adjust rate.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int RUN_HZ = 1,
  parameter int ADJ_HZ = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pause,
  input  logic       adj,
  input  logic       sel,
  output logic [4:0] min_l,
  output logic [4:0] min_r,
  output logic [4:0] sec_l,
  output logic [4:0] sec_r,
  output logic       running,
  output logic       blink
);

  localparam int RUN_DIV = CLK_HZ / RUN_HZ;
  localparam int ADJ_DIV = CLK_HZ / ADJ_HZ;

  state_t state;
  state_t state_next;

  logic   run_en;
  logic   run_tick;
  logic   adj_tick;

  digit_t min_l_next;
  digit_t min_r_next;
  digit_t sec_l_next;
  digit_t sec_r_next;

  // Run prescaler holds its value whenever counting is suspended, preserving the fractional second.
  assign run_en = (state == RUN) && !adj;

  tick_divider #(
    .DIV(RUN_DIV)
  ) u_run_div (
    .clk  (clk),
    .rst  (rst),
    .en   (run_en),
    .clr  (1'b0),
    .tick (run_tick)
  );

  tick_divider #(
    .DIV(ADJ_DIV)
  ) u_adj_div (
    .clk  (clk),
    .rst  (rst),
    .en   (adj),
    .clr  (!adj),
    .tick (adj_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PAUSED;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (pause) begin
      state_next = (state == RUN) ? PAUSED : RUN;
    end
  end

  assign running = (state == RUN);

  // run_tick and adj_tick are mutually exclusive because run_en requires adj low.
  always_comb begin
    min_l_next = min_l;
    min_r_next = min_r;
    sec_l_next = sec_l;
    sec_r_next = sec_r;
    if (run_tick) begin
      sec_r_next = digit_inc(sec_r, DIGIT_MAX);
      if (digit_wraps(sec_r, DIGIT_MAX)) begin
        sec_l_next = digit_inc(sec_l, SEC_TENS_MAX);
        if (digit_wraps(sec_l, SEC_TENS_MAX)) begin
          min_r_next = digit_inc(min_r, DIGIT_MAX);
          if (digit_wraps(min_r, DIGIT_MAX)) begin
            min_l_next = digit_inc(min_l, DIGIT_MAX);
          end
        end
      end
    end else if (adj_tick) begin
      if (!sel) begin
        sec_r_next = digit_inc(sec_r, DIGIT_MAX);
        if (digit_wraps(sec_r, DIGIT_MAX)) begin
          sec_l_next = digit_inc(sec_l, SEC_TENS_MAX);
        end
      end else begin
        min_r_next = digit_inc(min_r, DIGIT_MAX);
        if (digit_wraps(min_r, DIGIT_MAX)) begin
          min_l_next = digit_inc(min_l, DIGIT_MAX);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      min_l <= 5'd0;
      min_r <= 5'd0;
      sec_l <= 5'd0;
      sec_r <= 5'd0;
    end else begin
      min_l <= min_l_next;
      min_r <= min_r_next;
      sec_l <= sec_l_next;
      sec_r <= sec_r_next;
    end
  end

  // Blink flips at the adjust rate and is held on whenever adjust mode is off.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink <= 1'b1;
    end else if (!adj) begin
      blink <= 1'b1;
    end else if (adj_tick) begin
      blink <= ~blink;
    end
  end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter with RUN_DIV = 20 and ADJ_DIV = 5.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_stopwatch_counter;

  logic       clk;
  logic       rst;
  logic       pause;
  logic       adj;
  logic       sel;
  logic [4:0] min_l;
  logic [4:0] min_r;
  logic [4:0] sec_l;
  logic [4:0] sec_r;
  logic       running;
  logic       blink;
  logic [19:0] mmss;

  int tests_run;
  int tests_failed;
  logic [19:0] exp_q[$];

  stopwatch_counter #(
    .CLK_HZ(20),
    .RUN_HZ(1),
    .ADJ_HZ(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .pause   (pause),
    .adj     (adj),
    .sel     (sel),
    .min_l   (min_l),
    .min_r   (min_r),
    .sec_l   (sec_l),
    .sec_r   (sec_r),
    .running (running),
    .blink   (blink)
  );

  assign mmss = {min_l, min_r, sec_l, sec_r};

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [19:0] bcd(input int mm, input int ss);
    return {5'(mm / 10), 5'(mm % 10), 5'(ss / 10), 5'(ss % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_pause();
    pause = 1'b1;
    step(1);
    pause = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst   = 1'b1;
    pause = 1'b0;
    adj   = 1'b0;
    sel   = 1'b0;

    // reset and idle
    step(2);
    check("reset_digits", mmss, bcd(0, 0));
    check("reset_running", running, 1'b0);
    check("reset_blink", blink, 1'b1);
    rst = 1'b0;
    step(200);
    check("idle_digits", mmss, bcd(0, 0));
    check("idle_running", running, 1'b0);
    check("idle_blink", blink, 1'b1);

    // seconds carry through 01:00
    pulse_pause();
    check("start_running", running, 1'b1);
    for (int k = 1; k <= 60; k++) exp_q.push_back(bcd(k / 60, k % 60));
    step(19);
    check("first_tick_latency", mmss, bcd(0, 0));
    step(1);
    check("run_tick_1", mmss, exp_q.pop_front());
    for (int k = 2; k <= 60; k++) begin
      step(20);
      check($sformatf("run_tick_%0d", k), mmss, exp_q.pop_front());
    end

    // adjust to 99:59 while running, then wrap
    adj = 1'b1;
    sel = 1'b1;
    step(490);
    check("adj_min_to_99", mmss, bcd(99, 0));
    check("adj_running_kept", running, 1'b1);
    sel = 1'b0;
    step(295);
    check("adj_sec_to_59", mmss, bcd(99, 59));
    check("adj_blink_odd", blink, 1'b0);
    adj = 1'b0;
    step(1);
    check("blink_restored", blink, 1'b1);
    step(18);
    check("pre_wrap", mmss, bcd(99, 59));
    step(1);
    check("full_wrap", mmss, bcd(0, 0));
    check("wrap_running", running, 1'b1);

    // pause (run prescaler held at 1), then adjust seconds
    pulse_pause();
    check("paused", running, 1'b0);
    adj = 1'b1;
    sel = 1'b0;
    step(290);
    adj = 1'b0;
    step(1);
    check("prep_00_58", mmss, bcd(0, 58));
    check("prep_blink", blink, 1'b1);
    adj = 1'b1;
    step(4);
    check("adj_first_latency", mmss, bcd(0, 58));
    step(1);
    check("adj_sec_59", mmss, bcd(0, 59));
    check("adj_blink_1", blink, 1'b0);
    step(10);
    check("adj_sec_no_carry", mmss, bcd(0, 1));
    check("adj_blink_3", blink, 1'b0);
    sel = 1'b1;
    step(495);
    check("adj_min_99", mmss, bcd(99, 1));
    step(5);
    check("adj_min_wrap", mmss, bcd(0, 1));
    check("adj_blink_103", blink, 1'b0);
    adj = 1'b0;
    sel = 1'b0;
    step(1);
    check("adj_exit_blink", blink, 1'b1);
    check("adj_exit_paused", running, 1'b0);

    // resume from held prescaler value 1
    pulse_pause();
    check("resume_running", running, 1'b1);
    step(18);
    check("resume_pre_tick", mmss, bcd(0, 1));
    step(1);
    check("resume_fraction_kept", mmss, bcd(0, 2));

    // pause pulse in the run_tick cycle
    step(19);
    pulse_pause();
    check("coinc_increment", mmss, bcd(0, 3));
    check("coinc_running", running, 1'b0);
    step(100);
    check("hold_digits", mmss, bcd(0, 3));
    check("hold_running", running, 1'b0);
    pulse_pause();
    step(19);
    check("resume2_pre_tick", mmss, bcd(0, 3));
    step(1);
    check("resume2_tick", mmss, bcd(0, 4));

    // build 12:34 while running, then reset mid-run
    adj = 1'b1;
    sel = 1'b1;
    step(60);
    sel = 1'b0;
    step(150);
    adj = 1'b0;
    step(1);
    check("pre_reset_digits", mmss, bcd(12, 34));
    check("pre_reset_running", running, 1'b1);
    rst = 1'b1;
    step(1);
    check("mid_reset_digits", mmss, bcd(0, 0));
    check("mid_reset_running", running, 1'b0);
    check("mid_reset_blink", blink, 1'b1);
    pause = 1'b1;
    step(1);
    pause = 1'b0;
    check("reset_dominates_pause", running, 1'b0);
    rst = 1'b0;
    step(30);
    check("post_reset_idle", mmss, bcd(0, 0));

    // final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
